// File: rtl/lane_unstripe4.sv
// lane_unstripe4: buffers 4-lane words in a FIFO and serialises their valid lanes onto one byte stream.
// Define UNSTRIPE_BYTE_CNT_EN to add the byte_cnt output (16-bit count of accepted output bytes).
module lane_unstripe4 #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH:0]   in0,
  input  logic [WIDTH:0]   in1,
  input  logic [WIDTH:0]   in2,
  input  logic [WIDTH:0]   in3,
  output logic             in_ready,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             out_last
`ifdef UNSTRIPE_BYTE_CNT_EN
  ,
  output logic [15:0]      byte_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [3:0][WIDTH:0] mem [DEPTH];
  logic [3:0][WIDTH:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [1:0] lane_ptr, sel;
  logic [3:0] elig;
  logic push, pop, adv, load, last;
  assign in_ready = count < (AW+1)'(DEPTH);
  assign push = in_ready & (in0[WIDTH] | in1[WIDTH] | in2[WIDTH] | in3[WIDTH]);
  assign adv = ~out[WIDTH] | out_ready;
  assign load = adv & (count != '0);
  assign head = mem[rd_ptr];
  // lowest valid lane at or after lane_ptr; last when no valid lane remains above it
  always_comb begin
    elig = '0;
    sel = '0;
    for (int i = 3; i >= 0; i--) begin
      elig[i] = head[i][WIDTH] & (2'(i) >= lane_ptr);
      if (elig[i]) sel = 2'(i);
    end
  end
  assign last = ((elig >> sel) >> 1) == 4'd0;
  assign pop = load & last;
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = push ? SEND : IDLE;
    else if (out[WIDTH] && out_ready && out_last && count == '0 && !push)
      state_nx = IDLE;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in3, in2, in1, in0};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      lane_ptr <= '0;
      out <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (load) begin
        out <= head[sel];
        out_last <= last;
        lane_ptr <= last ? 2'd0 : sel + 2'd1;
      end else if (adv) begin
        out[WIDTH] <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end
`ifdef UNSTRIPE_BYTE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) byte_cnt <= '0;
    else if (out[WIDTH] && out_ready) byte_cnt <= byte_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_lane_unstripe4.sv
// tb_lane_unstripe4: directed and random stimulus checked against a byte-queue model of the unstriper.
module tb_lane_unstripe4;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_last;
  logic [8:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0, out;
  int total = 0, bad = 0, acc = 0;
  logic [7:0] byte_q[$];
  int len_q[$];
  logic m_v = 1'b0, m_last = 1'b0;
  logic [7:0] m_byte = '0;
`ifdef UNSTRIPE_BYTE_CNT_EN
  logic [15:0] byte_cnt;
  logic [15:0] m_cnt = '0;
`endif

  lane_unstripe4 #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .in_ready(in_ready), .out_ready(out_ready),
    .out(out), .out_last(out_last)
`ifdef UNSTRIPE_BYTE_CNT_EN
    , .byte_cnt(byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c, input logic [8:0] d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  // Model: the FIFO is a queue of remaining valid bytes plus the per-word count left.
  task automatic model_edge();
    logic [8:0] l[4];
    bit adv, push;
    int n;
    l = '{in0, in1, in2, in3};
    adv = !m_v || out_ready;
    push = len_q.size() < DEPTH && (in0[8] || in1[8] || in2[8] || in3[8]);
`ifdef UNSTRIPE_BYTE_CNT_EN
    if (m_v && out_ready) m_cnt = m_cnt + 16'd1;
`endif
    if (adv) begin
      if (len_q.size() > 0) begin
        m_byte = byte_q.pop_front();
        m_v = 1'b1;
        len_q[0] = len_q[0] - 1;
        m_last = len_q[0] == 0;
        if (m_last) void'(len_q.pop_front());
      end else begin
        m_v = 1'b0;
        m_last = 1'b0;
      end
    end
    if (push) begin
      n = 0;
      foreach (l[i]) if (l[i][8]) begin
        byte_q.push_back(l[i][7:0]);
        n++;
      end
      len_q.push_back(n);
    end
  endtask

  task automatic compare_all();
    check("in_ready", in_ready, 32'(len_q.size() < DEPTH));
    check("out_valid", out[8], m_v);
    if (m_v) check("out_byte", out[7:0], m_byte);
    check("out_last", out_last, m_last);
`ifdef UNSTRIPE_BYTE_CNT_EN
    check("byte_cnt", byte_cnt, m_cnt);
`endif
  endtask

  task automatic tick();
    acc += int'(out[8] & out_ready);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_out", out, 0);
    check("rst_last", out_last, 0);
    check("rst_ready", in_ready, 1);
    byte_q.delete();
    len_q.delete();
    m_v = 1'b0;
    m_last = 1'b0;
`ifdef UNSTRIPE_BYTE_CNT_EN
    m_cnt = '0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [8:0] rnd_lane(input bit v);
    return {v, 8'($urandom)};
  endfunction

  initial begin
    do_reset();
    out_ready = 1'b1;
    set_in(9'h1AA, 9'h1BB, 9'h1CC, 9'h1DD);
    tick();
    set_in('0, '0, '0, '0);
    tick(); check("fw0", out, 9'h1AA); check("fw0_last", out_last, 0);
    tick(); check("fw1", out, 9'h1BB); check("fw1_last", out_last, 0);
    tick(); check("fw2", out, 9'h1CC); check("fw2_last", out_last, 0);
    tick(); check("fw3", out, 9'h1DD); check("fw3_last", out_last, 1);
    tick(); check("fw_end", out[8], 0);
`ifdef UNSTRIPE_BYTE_CNT_EN
    check("fw_cnt", byte_cnt, 4);
`endif
    set_in(9'h111, 9'h022, 9'h133, 9'h044);
    tick();
    set_in('0, '0, '0, '0);
    tick(); check("sp0", out, 9'h111); check("sp0_last", out_last, 0);
    tick(); check("sp1", out, 9'h133); check("sp1_last", out_last, 1);
    tick(); check("sp_end", out[8], 0);
    out_ready = 1'b0;
    acc = 0;
    set_in(9'h101, 9'h102, 9'h103, 9'h104);
    tick();
    set_in(9'h105, 9'h106, 9'h107, 9'h108);
    tick(); check("bp_full", in_ready, 0);
    set_in(9'h109, 9'h10A, 9'h10B, 9'h10C);
    tick(); check("bp_hold", out, 9'h101);
    set_in('0, '0, '0, '0);
    tick(); check("bp_hold2", out, 9'h101);
    out_ready = 1'b1;
    repeat (12) tick();
    check("bp_total", acc, 8);
    for (int k = 0; k < 24; k++) begin
      if (k % 4 == 0) set_in(rnd_lane(1), rnd_lane(1), rnd_lane(1), rnd_lane(1));
      else set_in('0, '0, '0, '0);
      tick();
      if (k >= 1) check("b2b_valid", out[8], 1);
      check("b2b_ready", in_ready, 1);
    end
    set_in('0, '0, '0, '0);
    repeat (5) tick();
    set_in(9'h1F0, 9'h0F1, 9'h1F2, 9'h1F3);
    tick();
    set_in('0, '0, '0, '0);
    tick();
    tick();
    do_reset();
    check("rst_rel_out", out, 0);
    tick();
    check("rst_after", out, 0);
    repeat (3000) begin
      out_ready = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 9) < 3) set_in('0, '0, '0, '0);
      else set_in(rnd_lane($urandom_range(0, 2) != 0), rnd_lane($urandom_range(0, 2) != 0),
                  rnd_lane($urandom_range(0, 2) != 0), rnd_lane($urandom_range(0, 2) != 0));
      tick();
    end
    out_ready = 1'b1;
    set_in('0, '0, '0, '0);
    repeat (12) tick();
    check("drain_ready", in_ready, 1);
    check("drain_valid", out[8], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
